// File: rtl/odd_parity_serial_tx_if.sv
// Word handshake and serial-side status bundle for the odd-parity transmitter.
// master = upstream word source, slave = transmitter.
interface odd_parity_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic              parity;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx, busy, parity, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx, busy, parity, done
  );
endinterface

// File: rtl/odd_parity_serial_tx.sv
// Framed serial transmitter: start, DATA_W bits LSB first, odd parity, stop.
// Optional macro ODD_PARITY_TX_FORCE_ERR_EN adds force_err to invert the parity bit.
module odd_parity_serial_tx #(
  parameter int DATA_W   = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
  input  logic force_err,
`endif
  odd_parity_serial_tx_if.slave bus
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_baud;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_next;
  logic [CNT_W-1:0]  w_baud_next;
  logic [IDX_W-1:0]  w_idx_next;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_parity_next;
  logic              w_tx_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_accept;
  logic              w_wrap;
  logic              w_new_parity;

  assign w_accept = ~r_busy & bus.in_valid;
  assign w_wrap   = (r_baud == CNT_LAST);

`ifdef ODD_PARITY_TX_FORCE_ERR_EN
  assign w_new_parity = (~^bus.in_data) ^ force_err;
`else
  assign w_new_parity = ~^bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = w_wrap ? '0 : r_baud + 1'b1;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (w_accept) begin
          w_state_next  = S_START;
          w_shift_next  = bus.in_data;
          w_parity_next = w_new_parity;
          w_idx_next    = '0;
        end
      end
      S_START: begin
        if (w_wrap) w_state_next = S_DATA;
      end
      S_DATA: begin
        // shift register LSB is always the bit currently on the line
        if (w_wrap) begin
          if (r_idx == IDX_LAST) begin
            w_state_next = S_PARITY;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_wrap) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (r_state == S_STOP) && w_wrap;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.in_ready = ~r_busy;
  assign bus.parity   = r_parity;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Self-checking bench: two transmitters (BAUD_DIV 4 and 1) against a frame-list model.
module tb_odd_parity_serial_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   cur = 1'b0;

  always #5 clk = ~clk;

  odd_parity_serial_tx_if #(.DATA_W(4)) bus4 ();
  odd_parity_serial_tx_if #(.DATA_W(4)) bus1 ();

`ifdef ODD_PARITY_TX_FORCE_ERR_EN
  logic fe4 = 1'b0;
  logic fe1 = 1'b0;
`endif

  odd_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
    .force_err(fe4),
`endif
    .bus      (bus4.slave)
  );

  odd_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
    .force_err(fe1),
`endif
    .bus      (bus1.slave)
  );

  logic s_tx, s_busy, s_ready, s_par, s_done;
  assign s_tx    = cur ? bus1.tx       : bus4.tx;
  assign s_busy  = cur ? bus1.busy     : bus4.busy;
  assign s_ready = cur ? bus1.in_ready : bus4.in_ready;
  assign s_par   = cur ? bus1.parity   : bus4.parity;
  assign s_done  = cur ? bus1.done     : bus4.done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, cur ? 1 : 4, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic f);
    if (cur) begin
      bus1.in_valid = v;
      bus1.in_data  = d;
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
      fe1 = f;
`endif
    end else begin
      bus4.in_valid = v;
      bus4.in_data  = d;
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
      fe4 = f;
`endif
    end
    if (f === 1'bx) $display("[TB] note: unknown force value");
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One whole frame: accept, then every cycle of the frame, then the done cycle.
  task automatic frame(input logic [3:0] data, input bit ferr, input bit chain);
    int   b;
    int   ones;
    logic exp_par;
    logic [6:0] bits;
    b = cur ? 1 : 4;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(data[i]);
    exp_par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    exp_par = exp_par ^ ferr;
    bits[0] = 1'b0;
    for (int i = 0; i < 4; i++) bits[1+i] = data[i];
    bits[5] = exp_par;
    bits[6] = 1'b1;

    check("ready_before_accept", {31'd0, s_ready}, 32'd1);
    drive(1'b1, data, ferr);
    tick();
    check("busy_after_accept", {31'd0, s_busy}, 32'd1);
    check("ready_after_accept", {31'd0, s_ready}, 32'd0);
    check("parity_latched", {31'd0, s_par}, {31'd0, exp_par});
    for (int t = 0; t < b * 7; t++) begin
      check($sformatf("tx_slot%0d_cyc%0d", t / b, t), {31'd0, s_tx}, {31'd0, bits[t / b]});
      check("done_low_in_frame", {31'd0, s_done}, 32'd0);
      // Words offered while busy must be ignored and must not disturb the frame.
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    check("done_pulse", {31'd0, s_done}, 32'd1);
    check("idle_after_frame", {31'd0, s_busy}, 32'd0);
    check("ready_after_frame", {31'd0, s_ready}, 32'd1);
    check("tx_high_after_frame", {31'd0, s_tx}, 32'd1);
    check("parity_held", {31'd0, s_par}, {31'd0, exp_par});
    $display("[TB] dut%0d frame data=%b ferr=%0d parity=%0d chain=%0d", b, data, ferr, exp_par, chain);
    if (!chain) begin
      drive(1'b0, 4'($urandom), 1'b0);
      tick();
      check("done_one_cycle", {31'd0, s_done}, 32'd0);
      check("tx_idle_high", {31'd0, s_tx}, 32'd1);
      check("parity_hold_idle", {31'd0, s_par}, {31'd0, exp_par});
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;

    // Reset held for three edges on both instances.
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      cur = bit'(k);
      #0;
      check("rst_tx", {31'd0, s_tx}, 32'd1);
      check("rst_busy", {31'd0, s_busy}, 32'd0);
      check("rst_ready", {31'd0, s_ready}, 32'd1);
      check("rst_done", {31'd0, s_done}, 32'd0);
      check("rst_parity", {31'd0, s_par}, 32'd0);
    end
    rst_n = 1'b1;
    cur = 1'b0;
    tick();

    frame(4'b0101, 1'b0, 1'b0);
    frame(4'b1101, 1'b0, 1'b1);
    frame(4'b0000, 1'b0, 1'b0);

    cur = 1'b1;
    #0;
    frame(4'b1111, 1'b0, 1'b0);

    // Abort a frame during DATA with a one-cycle reset.
    cur = 1'b0;
    #0;
    drive(1'b1, 4'b1001, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0);
    repeat (10) tick();
    check("abort_in_frame", {31'd0, s_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_tx_high", {31'd0, s_tx}, 32'd1);
    check("abort_busy", {31'd0, s_busy}, 32'd0);
    check("abort_ready", {31'd0, s_ready}, 32'd1);
    check("abort_parity", {31'd0, s_par}, 32'd0);
    for (int t = 0; t < 32; t++) begin
      check("abort_no_done", {31'd0, s_done}, 32'd0);
      check("abort_line_idle", {31'd0, s_tx}, 32'd1);
      tick();
    end
    frame(4'b1001, 1'b0, 1'b0);

`ifdef ODD_PARITY_TX_FORCE_ERR_EN
    for (int k = 0; k < 2; k++) begin
      cur = bit'(k);
      #0;
      frame(4'b0101, 1'b1, 1'b0);
      frame(4'b0101, 1'b0, 1'b0);
    end
`endif

    // Random frames on either instance; chained frames stay on the same one.
    cur = 1'b0;
    for (int n = 0; n < 16; n++) begin
      bit chain;
      bit ferr;
      chain = 1'($urandom_range(0, 1));
      ferr = 1'b0;
`ifdef ODD_PARITY_TX_FORCE_ERR_EN
      ferr = 1'($urandom_range(0, 1));
`endif
      if (n == 15) chain = 1'b0;
      frame(4'($urandom), ferr, chain);
      if (!chain) begin
        cur = 1'($urandom_range(0, 1));
        #0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
Serial transmitter that is the sending end of the odd-parity link. It accepts a DATA_W-bit word over a valid/ready handshake, computes the odd parity bit, and shifts out a framed serial stream: start bit, data bits LSB first, odd parity bit, stop bit. The downstream odd-parity checker consumes this stream. Total ones across data plus parity is always odd.

Parameters:
DATA_W, 4, payload width in bits (>=1)
BAUD_DIV, 4, clock cycles each serial bit is held on tx (>=1; 1 is legal)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  DATA_W  word to transmit
in_ready  output  1  block can accept a word (high only in IDLE)
tx  output  1  registered serial line, idles high
busy  output  1  frame in progress (START..STOP)
parity  output  1  odd parity bit of the word last accepted (registered)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, tx=1, busy=0, in_ready=1, parity=0, done=0, counters=0. Takes priority over all other activity.
- Reset mid-frame aborts the frame. The line returns high on the next edge, no done pulse is issued, and the word is discarded.
- Frame bit count is DATA_W+3. Frame duration is BAUD_DIV*(DATA_W+3) cycles.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - in_ready=1, tx=1, busy=0.
  - Accept occurs on an edge where in_valid & in_ready. On that edge: latch in_data into the shift register, set parity = ~^in_data, move to START.
- START: tx=0 for BAUD_DIV cycles.
- DATA:
  - tx = data bit i, LSB first, i = 0..DATA_W-1.
  - Each bit is held BAUD_DIV cycles.
  - A bit index counts 0..DATA_W-1, then the block moves to PARITY.
- PARITY: tx = parity register for BAUD_DIV cycles.
- STOP: tx=1 for BAUD_DIV cycles, then move to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 in every non-IDLE state.
  - The state or bit advances when the counter equals BAUD_DIV-1, and the counter wraps to 0.
  - BAUD_DIV=1 advances every cycle.
- Timing relative to accept edge k:
  - tx=0 is visible after edge k.
  - Data bit i is visible after edge k+BAUD_DIV*(1+i).
  - Parity is visible after edge k+BAUD_DIV*(DATA_W+1).
  - Stop is visible after edge k+BAUD_DIV*(DATA_W+2).
  - After edge k+BAUD_DIV*(DATA_W+3): IDLE, done=1 for exactly that one cycle, in_ready=1.
- Back-to-back frames: a word presented with in_valid during the done cycle is accepted on the following edge. Minimum gap between frames is one idle-high cycle.
- in_valid while busy is ignored (in_ready=0). in_data changes after accept have no effect on the frame in flight.
- busy = (state != IDLE), registered alongside state. in_ready = ~busy.
- The parity output holds its value after the frame until the next accept or reset.

Optional Feature:
Macro ODD_PARITY_TX_FORCE_ERR_EN.
- Defined:
  - Adds input port force_err (1 bit).
  - If force_err=1 on the accept edge, the latched parity bit is inverted (parity = ^in_data). The frame then carries even total parity, for exercising the checker's error path.
  - force_err is sampled only at accept.
- Not defined: the port is absent and parity is always ~^in_data.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> tx=1, busy=0, in_ready=1, done=0, parity=0.
- Send in_data=4'b0101, DATA_W=4, BAUD_DIV=4:
  - After accept, tx sequence per 4-cycle slot is 0,1,0,1,0,1,1 (start, d0..d3, parity, stop).
  - parity=1.
  - done pulses at accept+28 cycles.
- Send 4'b1101 then 4'b0000 back-to-back, with in_valid held high through the done cycle:
  - Parity bits are 0 then 1.
  - The second start bit begins exactly 1 cycle after the first done.
- BAUD_DIV=1, in_data=4'b1111 -> 7-cycle frame 0,1,1,1,1,1,1, parity=1, done at accept+7.
- Assert rst_n=0 for 1 cycle during the DATA state of a 4'b1001 frame -> tx=1 on the next edge, no done pulse. A new word accepted afterwards transmits correctly.
- With ODD_PARITY_TX_FORCE_ERR_EN, force_err=1, in_data=4'b0101 -> parity slot carries 0; the checker flags an error. With force_err=0 it carries 1.
